// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg                                                            |
// | Default geometry and instruction-field layout of the datapath.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cpu_pkg;

    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
    localparam int DATA_W   = 32;
    localparam int OPC_W    = 5;
    localparam int IMM_W    = 19;

    localparam int OPC_LSB  = DATA_W - OPC_W;
    localparam int RA_LSB   = OPC_LSB - IDX_W;
    localparam int RB_LSB   = RA_LSB - IDX_W;
    localparam int RC_LSB   = RB_LSB - IDX_W;

    typedef logic [IDX_W-1:0] reg_idx_t;

    // Register fields are packed directly below the opcode: 0=ra, 1=rb, 2=rc.
    function automatic int field_lsb(input int data_w, input int opc_w,
                                     input int idx_w, input int field);
        return data_w - opc_w - idx_w * (field + 1);
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/sel_encode_sb_onehot_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | onehot_decoder                                                     |
// | Index to one-hot enable vector; indices >= NUM_REGS decode to 0.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module onehot_decoder #(
    parameter int IDX_W    = 4,
    parameter int NUM_REGS = 16
) (
    input  logic [IDX_W-1:0]    i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    import cpu_pkg::*;

    // Only in-range positions exist, so an out-of-range index matches nothing.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
        assign o_onehot[i] = i_en && (i_idx == IDX_W'(i));
    end

endmodule : onehot_decoder
`default_nettype wire

// File: rtl/sel_encode_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sel_encode_sb                                                      |
// | Instruction register, register select/encode and write scoreboard. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sel_encode_sb #(
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int IDX_W    = cpu_pkg::IDX_W,
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int OPC_W    = cpu_pkg::OPC_W,
    parameter int IMM_W    = cpu_pkg::IMM_W
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                ir_load,
    input  logic [DATA_W-1:0]   ir_in,
    input  logic                Gra,
    input  logic                Grb,
    input  logic                Grc,
    input  logic                Rin,
    input  logic                Rout,
    input  logic                BAout,
    input  logic                issue,
    input  logic                use_rb,
    input  logic                use_rc,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_idx,
    output logic [DATA_W-1:0]   ir_q,
    output logic [OPC_W-1:0]    OP,
    output logic [NUM_REGS-1:0] GenReg_In,
    output logic [NUM_REGS-1:0] GenReg_Out,
    output logic                r0_zero,
    output logic [DATA_W-1:0]   C_sign_extended,
    output logic [NUM_REGS-1:0] busy,
    output logic                stall
);

    import cpu_pkg::*;

    localparam int c_RA_LSB = field_lsb(DATA_W, OPC_W, IDX_W, 0);
    localparam int c_RB_LSB = field_lsb(DATA_W, OPC_W, IDX_W, 1);
    localparam int c_RC_LSB = field_lsb(DATA_W, OPC_W, IDX_W, 2);

    logic [DATA_W-1:0]   r_ir_q;
    logic [DATA_W-1:0]   w_ir_d;
    logic [NUM_REGS-1:0] r_busy_q;
    logic [NUM_REGS-1:0] w_busy_d;

    logic [IDX_W-1:0]    w_ra;
    logic [IDX_W-1:0]    w_rb;
    logic [IDX_W-1:0]    w_rc;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_sel_vld;
    logic [NUM_REGS-1:0] w_sel_oh;

    logic [NUM_REGS-1:0] w_ra_oh;
    logic [NUM_REGS-1:0] w_rb_oh;
    logic [NUM_REGS-1:0] w_rc_oh;
    logic [NUM_REGS-1:0] w_wb_oh;
    logic [NUM_REGS-1:0] w_live;
    logic                w_hz_ra;
    logic                w_hz_rb;
    logic                w_hz_rc;
    logic                w_accept;

    // ------------------------------------------------------------------
    // Field extraction and operand select
    // ------------------------------------------------------------------
    assign w_ra = r_ir_q[c_RA_LSB +: IDX_W];
    assign w_rb = r_ir_q[c_RB_LSB +: IDX_W];
    assign w_rc = r_ir_q[c_RC_LSB +: IDX_W];

    always_comb begin
        w_sel_vld = Gra | Grb | Grc;
        w_sel_idx = '0;
        if (Gra) begin
            w_sel_idx = w_ra;
        end else if (Grb) begin
            w_sel_idx = w_rb;
        end else if (Grc) begin
            w_sel_idx = w_rc;
        end
    end

    onehot_decoder #(
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_sel_dec (
        .i_idx    (w_sel_idx),
        .i_en     (w_sel_vld),
        .o_onehot (w_sel_oh)
    );

    // A base-address read of R0 means "address zero", so R0 stays off the bus.
    assign r0_zero    = BAout & w_sel_vld & (w_sel_idx == '0);
    assign GenReg_In  = Rin ? w_sel_oh : '0;
    assign GenReg_Out = ((Rout | BAout) & ~r0_zero) ? w_sel_oh : '0;

    assign ir_q            = r_ir_q;
    assign OP              = r_ir_q[DATA_W-1 -: OPC_W];
    assign C_sign_extended = {{(DATA_W-IMM_W){r_ir_q[IMM_W-1]}}, r_ir_q[IMM_W-1:0]};

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_idx_match
        assign w_ra_oh[i] = (w_ra == IDX_W'(i));
        assign w_rb_oh[i] = (w_rb == IDX_W'(i));
        assign w_rc_oh[i] = (w_rc == IDX_W'(i));
        assign w_wb_oh[i] = wb_valid && (wb_idx == IDX_W'(i));
    end

    // A writeback landing this cycle no longer counts as pending.
    assign w_live   = r_busy_q & ~w_wb_oh;
    assign w_hz_ra  = |(w_live & w_ra_oh);
    assign w_hz_rb  = |(w_live & w_rb_oh);
    assign w_hz_rc  = |(w_live & w_rc_oh);

    assign stall    = issue & (w_hz_ra | (use_rb & w_hz_rb) | (use_rc & w_hz_rc));
    assign w_accept = issue & ~stall;

    // Set is applied after clear so a same-index claim survives its writeback.
    assign w_busy_d = (r_busy_q & ~w_wb_oh) | (w_accept ? w_ra_oh : '0);
    assign w_ir_d   = ir_load ? ir_in : r_ir_q;
    assign busy     = r_busy_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_ir_q   <= '0;
            r_busy_q <= '0;
        end else begin
            r_ir_q   <= w_ir_d;
            r_busy_q <= w_busy_d;
        end
    end

endmodule : sel_encode_sb
`default_nettype wire

// File: tb/tb_sel_encode_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sel_encode_sb                                                   |
// | Directed scenarios plus random traffic against a behavioural model.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sel_encode_sb;

    import cpu_pkg::*;

    logic        clock;
    logic        clear;
    logic        ir_load;
    logic [31:0] ir_in;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        issue, use_rb, use_rc, wb_valid;
    logic [3:0]  wb_idx;
    logic [31:0] ir_q;
    logic [4:0]  OP;
    logic [15:0] GenReg_In, GenReg_Out;
    logic        r0_zero;
    logic [31:0] C_sign_extended;
    logic [15:0] busy;
    logic        stall;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_ir;
    logic [15:0] m_busy;

    sel_encode_sb #(
        .NUM_REGS (16), .IDX_W (4), .DATA_W (32), .OPC_W (5), .IMM_W (19)
    ) dut (
        .clock (clock), .clear (clear), .ir_load (ir_load), .ir_in (ir_in),
        .Gra (Gra), .Grb (Grb), .Grc (Grc), .Rin (Rin), .Rout (Rout), .BAout (BAout),
        .issue (issue), .use_rb (use_rb), .use_rc (use_rc),
        .wb_valid (wb_valid), .wb_idx (wb_idx),
        .ir_q (ir_q), .OP (OP), .GenReg_In (GenReg_In), .GenReg_Out (GenReg_Out),
        .r0_zero (r0_zero), .C_sign_extended (C_sign_extended),
        .busy (busy), .stall (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mk_ir(input logic [31:0] op, input logic [31:0] ra,
                                          input logic [31:0] rb, input logic [31:0] rc,
                                          input logic [31:0] imm);
        return (op << 27) | (ra << 23) | (rb << 19) | (rc << 15) | imm;
    endfunction

    function automatic int fld(input logic [31:0] ir, input int lsb);
        return int'((ir >> lsb) % 32'd16);
    endfunction

    function automatic logic model_hz(input int r);
        return m_busy[r] && !(wb_valid && (int'(wb_idx) == r));
    endfunction

    function automatic logic model_stall();
        return issue && (model_hz(fld(m_ir, 23)) ||
                         (use_rb && model_hz(fld(m_ir, 19))) ||
                         (use_rc && model_hz(fld(m_ir, 15))));
    endfunction

    task automatic model_edge();
        logic acc;
        int   ra;
        if (clear) begin
            m_ir   = '0;
            m_busy = '0;
        end else begin
            acc = model_stall() ? 1'b0 : issue;
            ra  = fld(m_ir, 23);
            if (wb_valid) m_busy[wb_idx] = 1'b0;
            if (acc) m_busy[ra] = 1'b1;
            if (ir_load) m_ir = ir_in;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        clear = 0; ir_load = 0; ir_in = '0;
        Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
        issue = 0; use_rb = 0; use_rc = 0; wb_valid = 0; wb_idx = '0;
    endtask

    task automatic do_clear();
        idle(); clear = 1; tick(); clear = 0;
    endtask

    task automatic load_ir(input logic [31:0] v);
        ir_load = 1; ir_in = v; tick(); ir_load = 0;
    endtask

    task automatic test_reset();
        do_clear();
        checks++; if (ir_q !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h expected %h", ir_q, 32'h0); end
        checks++; if (OP !== 5'h0) begin errors++; $display("FAIL reset_op: got %h expected %h", OP, 5'h0); end
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy, 16'h0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        load_ir(32'h2A8C_0000);
        checks++; if (ir_q !== 32'h2A8C_0000) begin errors++; $display("FAIL ir_load: got %h expected %h", ir_q, 32'h2A8C_0000); end
        checks++; if (OP !== 5'h05) begin errors++; $display("FAIL op_field: got %h expected %h", OP, 5'h05); end
        Gra = 1; Rin = 1; #1;
        checks++; if (GenReg_In !== 16'h0020) begin errors++; $display("FAIL ra_in: got %h expected %h", GenReg_In, 16'h0020); end
        Gra = 0; Grb = 1; #1;
        checks++; if (GenReg_In !== 16'h0002) begin errors++; $display("FAIL rb_in: got %h expected %h", GenReg_In, 16'h0002); end
        Grb = 0; Grc = 1; #1;
        checks++; if (GenReg_In !== 16'h0100) begin errors++; $display("FAIL rc_in: got %h expected %h", GenReg_In, 16'h0100); end
        Grc = 0; #1;
        checks++; if (GenReg_In !== 16'h0) begin errors++; $display("FAIL no_sel_in: got %h expected %h", GenReg_In, 16'h0); end
        idle(); clear = 1; ir_load = 1; ir_in = 32'hFFFF_FFFF; tick(); idle();
        checks++; if (ir_q !== 32'h0) begin errors++; $display("FAIL clear_over_load: got %h expected %h", ir_q, 32'h0); end
    endtask

    task automatic test_priority_sext();
        load_ir(32'h2A8C_0000);
        Gra = 1; Grb = 1; Grc = 1; Rout = 1; #1;
        checks++; if (GenReg_Out !== 16'h0020) begin errors++; $display("FAIL priority_out: got %h expected %h", GenReg_Out, 16'h0020); end
        checks++; if (GenReg_In !== 16'h0) begin errors++; $display("FAIL priority_in_gated: got %h expected %h", GenReg_In, 16'h0); end
        idle();
        load_ir(32'h0004_0003);
        checks++; if (C_sign_extended !== 32'hFFFC_0003) begin errors++; $display("FAIL sext_neg: got %h expected %h", C_sign_extended, 32'hFFFC_0003); end
        load_ir(32'h0003_FFFF);
        checks++; if (C_sign_extended !== 32'h0003_FFFF) begin errors++; $display("FAIL sext_pos: got %h expected %h", C_sign_extended, 32'h0003_FFFF); end
    endtask

    task automatic test_baout();
        load_ir(mk_ir(1, 9, 0, 2, 0));
        Grb = 1; BAout = 1; #1;
        checks++; if (GenReg_Out !== 16'h0) begin errors++; $display("FAIL ba_r0_out: got %h expected %h", GenReg_Out, 16'h0); end
        checks++; if (r0_zero !== 1'b1) begin errors++; $display("FAIL ba_r0_zero: got %b expected 1", r0_zero); end
        idle();
        load_ir(mk_ir(1, 9, 3, 2, 0));
        Grb = 1; BAout = 1; #1;
        checks++; if (GenReg_Out !== 16'h0008) begin errors++; $display("FAIL ba_r3_out: got %h expected %h", GenReg_Out, 16'h0008); end
        checks++; if (r0_zero !== 1'b0) begin errors++; $display("FAIL ba_r3_zero: got %b expected 0", r0_zero); end
        idle();
    endtask

    task automatic test_raw();
        do_clear();
        load_ir(mk_ir(1, 4, 0, 0, 0));
        issue = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_stall: got %b expected 0", stall); end
        tick(); issue = 0;
        checks++; if (busy !== 16'h0010) begin errors++; $display("FAIL raw_claim: got %h expected %h", busy, 16'h0010); end
        load_ir(mk_ir(2, 6, 4, 0, 0));
        issue = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_unused_rb: got %b expected 0", stall); end
        use_rb = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b expected 1", stall); end
        tick();
        checks++; if (busy !== 16'h0010) begin errors++; $display("FAIL raw_hold: got %h expected %h", busy, 16'h0010); end
        wb_valid = 1; wb_idx = 4; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_bypass: got %b expected 0", stall); end
        tick(); idle();
        checks++; if (busy !== 16'h0040) begin errors++; $display("FAIL raw_after: got %h expected %h", busy, 16'h0040); end
    endtask

    task automatic test_waw();
        do_clear();
        load_ir(mk_ir(3, 7, 1, 2, 0));
        issue = 1; tick();
        checks++; if (busy !== 16'h0080) begin errors++; $display("FAIL waw_claim: got %h expected %h", busy, 16'h0080); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b expected 1", stall); end
        wb_valid = 1; wb_idx = 7; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_bypass: got %b expected 0", stall); end
        tick(); idle();
        checks++; if (busy !== 16'h0080) begin errors++; $display("FAIL set_wins: got %h expected %h", busy, 16'h0080); end
    endtask

    task automatic test_clear_mid();
        do_clear();
        for (int r = 4; r < 8; r++) begin
            load_ir(mk_ir(1, r, 0, 0, 0));
            issue = 1; tick(); issue = 0;
        end
        checks++; if (busy !== 16'h00F0) begin errors++; $display("FAIL fill_busy: got %h expected %h", busy, 16'h00F0); end
        load_ir(mk_ir(1, 2, 0, 0, 0));
        clear = 1; issue = 1; tick(); idle();
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL clear_busy: got %h expected %h", busy, 16'h0); end
        checks++; if (ir_q !== 32'h0) begin errors++; $display("FAIL clear_ir: got %h expected %h", ir_q, 32'h0); end
        wb_valid = 1; wb_idx = 5; tick(); idle();
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL stale_wb: got %h expected %h", busy, 16'h0); end
    endtask

    task automatic test_random();
        int          sel;
        logic        vld, e_r0, e_stall;
        logic [15:0] oh, e_in, e_out;
        logic [31:0] imm, e_sext;
        do_clear();
        for (int n = 0; n < 400; n++) begin
            clear    = ($urandom % 50) == 0;
            ir_load  = ($urandom % 3) == 0;
            ir_in    = $urandom;
            Gra = 1'($urandom % 2); Grb = 1'($urandom % 2); Grc = 1'($urandom % 2);
            Rin = 1'($urandom % 2); Rout = 1'($urandom % 2); BAout = 1'($urandom % 2);
            issue    = ($urandom % 3) != 0;
            use_rb   = 1'($urandom % 2);
            use_rc   = 1'($urandom % 2);
            wb_valid = ($urandom % 2) == 0;
            wb_idx   = 4'($urandom % 16);
            #1;
            vld = Gra || Grb || Grc;
            sel = Gra ? fld(m_ir, 23) : Grb ? fld(m_ir, 19) : Grc ? fld(m_ir, 15) : 0;
            oh  = vld ? 16'(32'd1 << sel) : 16'h0;
            e_r0  = BAout && vld && (sel == 0);
            e_in  = Rin ? oh : 16'h0;
            e_out = ((Rout || BAout) && !e_r0) ? oh : 16'h0;
            imm   = m_ir % 32'h8_0000;
            e_sext = (imm >= 32'h4_0000) ? imm + 32'hFFF8_0000 : imm;
            e_stall = model_stall();
            checks++; if (ir_q !== m_ir) begin errors++; $display("FAIL rnd_ir[%0d]: got %h expected %h", n, ir_q, m_ir); end
            checks++; if (OP !== 5'(m_ir >> 27)) begin errors++; $display("FAIL rnd_op[%0d]: got %h expected %h", n, OP, m_ir >> 27); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %h expected %h", n, busy, m_busy); end
            checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", n, stall, e_stall); end
            checks++; if (GenReg_In !== e_in) begin errors++; $display("FAIL rnd_in[%0d]: got %h expected %h", n, GenReg_In, e_in); end
            checks++; if (GenReg_Out !== e_out) begin errors++; $display("FAIL rnd_out[%0d]: got %h expected %h", n, GenReg_Out, e_out); end
            checks++; if (r0_zero !== e_r0) begin errors++; $display("FAIL rnd_r0[%0d]: got %b expected %b", n, r0_zero, e_r0); end
            checks++; if (C_sign_extended !== e_sext) begin errors++; $display("FAIL rnd_sext[%0d]: got %h expected %h", n, C_sign_extended, e_sext); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        m_ir   = '0;
        m_busy = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_priority_sext();
        test_baout();
        test_raw();
        test_waw();
        test_clear_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sel_encode_sb
`default_nettype wire
